tick_rate_detector: RTL and testbench
=====================================

Name: tick_rate_detector

Overview:
- Receive end of the tick-selection path: takes a selected 0.5/1/2 Hz tick or clock stream and decodes which rate it is.
- Returns the matching 2-bit select code, so a selector's setting can be verified in-system.
- Sits next to the clock divider/mux on the same board clock.
- Measures the rising-edge period in clki cycles, classifies it with tolerance, and requires two matching periods before asserting lock.

Parameters:
- CLK_HZ, 50000000, clki frequency in Hz. Must be divisible by 16 and ≥16; the bench uses 80.
- TIMEOUT, 3*CLK_HZ, number of clki cycles with no edge before lock is dropped.

Ports:
- clki  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- E  input  1  detector enable; 0 forces the idle state.
- tick_in  input  1  asynchronous tick/clock stream under test.
- S_det  output  2  decoded code: 00=0.5 Hz, 01=1 Hz, 10=2 Hz, 11=none/unknown.
- locked  output  1  S_det is valid.
- change  output  1  one-cycle pulse whenever S_det changes value.

Behaviour:
- Reset (async, rst=1): S_det=11, locked=0, change=0, state=IDLE, counter=0, candidate=11, match_cnt=0.
- Input capture: tick_in passes through a 2-FF synchroniser, then a rising-edge detect register. `edge` is a one-cycle pulse 3 clki cycles after the tick_in rise.
  - Any pulse width ≥1 clki cycle is accepted.
  - High-time is irrelevant; only rising edges count.
- Period counter: counts clki cycles since the last `edge`.
  - On an `edge` cycle: P = counter, then counter <= 1.
  - Otherwise counter increments, saturating at TIMEOUT.
  - Edges at cycles t0 and t1 give P = t1 - t0.
  - Counter width = clog2(TIMEOUT+1).
- Nominal periods and accept windows (bounds inclusive):
  - N00 = 2*CLK_HZ, window N ± N/8.
  - N01 = CLK_HZ, window N ± N/8.
  - N10 = CLK_HZ/2, window N ± N/8.
  - The windows never overlap. Any other P classifies as 11 (invalid).
- State machine:
  - IDLE: waiting for the first edge. On `edge` -> MEASURE; no period is evaluated.
  - MEASURE, on each `edge`, classify P into class C:
    - C==11: candidate=11, match_cnt=0.
    - C==candidate: match_cnt++ (saturate at 2).
    - Otherwise: candidate=C, match_cnt=1.
    - When match_cnt reaches 2 -> LOCKED. S_det=C and locked=1 in the cycle after that `edge`.
  - LOCKED, on each `edge`:
    - C==S_det: stay LOCKED.
    - Otherwise: locked=0, S_det=11 the next cycle, return to MEASURE with candidate=C, match_cnt = (C==11 ? 0 : 1).
  - Timeout: if counter reaches TIMEOUT in MEASURE or LOCKED, go to IDLE next cycle with S_det=11, locked=0. The next edge is treated as a first edge.
- Enable:
  - E=0 synchronously forces IDLE, S_det=11, locked=0, counter=0 on the next clki.
  - After E returns to 1, the first edge only starts measurement.
- change: registered. It is 1 for exactly one cycle, in the same cycle S_det takes a new value (including a drop to 11). It is never asserted by reset.
- Simultaneous events: `edge` in the same cycle as counter==TIMEOUT means the edge wins. P is treated as TIMEOUT and classified; it is invalid unless it falls inside a window.
- Invariants:
  - locked==1 implies S_det≠11.
  - S_det only changes on the cycle after an `edge`, a timeout, or E=0.

Decomposition:
- Shared include file:
  - code localparams CODE_0P5=2'b00, CODE_1=2'b01, CODE_2=2'b10, CODE_NONE=2'b11.
  - state encodings ST_IDLE, ST_MEASURE, ST_LOCKED.
- One sub-module: edge_sync.
  - 2-FF synchroniser plus rising-edge pulse.
  - Ports clki, rst, d, rise.
  - Reusable by other blocks taking external ticks.
- Period classification stays in the top module as combinational logic.

Test Plan (CLK_HZ=80, so windows are 00:[140,180], 01:[70,90], 10:[35,45]; TIMEOUT=240):
1. rst pulsed mid-count while locked at 01 -> S_det=11, locked=0 immediately (asynchronously). Relock requires 3 fresh edges.
2. E=1, tick_in square wave with period 80 -> after the 3rd detected edge, S_det=01, locked=1, and a single change pulse in the same cycle. These stay stable over 10 further periods.
3. Period 40 -> lock to 10. Then switch to period 160 -> on the first 160 period, locked=0, S_det=11, change=1. After the second 160 period, S_det=00, locked=1, change=1.
4. Boundaries:
   - period 90 -> locks at 01.
   - period 91 -> never locks, S_det stays 11.
   - period 35 -> locks at 10; period 34 -> no lock.
5. Locked at 00, then tick_in held low -> exactly 240 cycles after the last edge, S_det=11, locked=0, change=1. A single new edge does not relock.
6. Locked at 01, E deasserted for 5 cycles -> next cycle S_det=11, locked=0. On re-enable, lock returns after 3 edges (the first edge is not counted as a period).

Source files
------------

// File: rtl/tick_rate_detector_pkg.sv
// Shared definitions for the tick-rate detector: select codes, FSM states
// and accept-window helpers used to derive the classification bounds.
package tick_rate_detector_pkg;

  localparam logic [1:0] CODE_0P5  = 2'b00;
  localparam logic [1:0] CODE_1    = 2'b01;
  localparam logic [1:0] CODE_2    = 2'b10;
  localparam logic [1:0] CODE_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MEASURE = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  // Inclusive accept window around a nominal period: N +/- N/8.
  function automatic int win_lo(input int nom);
    return nom - nom / 8;
  endfunction

  function automatic int win_hi(input int nom);
    return nom + nom / 8;
  endfunction

endpackage

// File: rtl/tick_rate_detector_if.sv
// Control/status bundle of the tick-rate detector: enable and tick stream in,
// decoded select code, lock and change pulse out.
interface tick_rate_if;
  logic       E;
  logic       tick_in;
  logic [1:0] S_det;
  logic       locked;
  logic       change;

  modport master (output E, tick_in, input S_det, locked, change);
  modport slave  (input E, tick_in, output S_det, locked, change);
endinterface

// File: rtl/tick_rate_detector_edge_sync.sv
// Brings an asynchronous level into the clki domain and emits a one-cycle
// pulse on each rising edge, three cycles after the input rises.
module edge_sync (
  input  logic clki,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  // NOTE: s1/s2 form the metastability guard; only s2 onward may feed logic.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/tick_rate_detector.sv
// Measures the rising-edge period of a selected tick stream and decodes it
// back to the 0.5/1/2 Hz select code, locking after two matching periods.
module tick_rate_detector
  import tick_rate_detector_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TIMEOUT = 3 * CLK_HZ
) (
  input  logic        clki,
  input  logic        rst,
  tick_rate_if.slave  bus
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] LO_0P5  = CW'(win_lo(2 * CLK_HZ));
  localparam logic [CW-1:0] HI_0P5  = CW'(win_hi(2 * CLK_HZ));
  localparam logic [CW-1:0] LO_1    = CW'(win_lo(CLK_HZ));
  localparam logic [CW-1:0] HI_1    = CW'(win_hi(CLK_HZ));
  localparam logic [CW-1:0] LO_2    = CW'(win_lo(CLK_HZ / 2));
  localparam logic [CW-1:0] HI_2    = CW'(win_hi(CLK_HZ / 2));

  logic          tick_edge;
  logic [CW-1:0] cnt;
  logic [1:0]    cls;
  state_t        state;
  logic [1:0]    s_det;
  logic [1:0]    cand;
  logic [1:0]    match_cnt;
  logic          locked_q;
  logic          change_q;

  edge_sync u_edge_sync (
    .clki (clki),
    .rst  (rst),
    .d    (bus.tick_in),
    .rise (tick_edge)
  );

  // Cycles since the last edge; on an edge cycle cnt is the measured period.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!bus.E) begin
      cnt <= '0;
    end else if (tick_edge) begin
      cnt <= CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // NOTE: default-first assignment keeps this purely combinational (no latch).
  always_comb begin
    cls = CODE_NONE;
    if (cnt >= LO_0P5 && cnt <= HI_0P5)    cls = CODE_0P5;
    else if (cnt >= LO_1 && cnt <= HI_1)   cls = CODE_1;
    else if (cnt >= LO_2 && cnt <= HI_2)   cls = CODE_2;
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s_det     <= CODE_NONE;
      cand      <= CODE_NONE;
      match_cnt <= 2'd0;
      locked_q  <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (!bus.E) begin
        state     <= ST_IDLE;
        cand      <= CODE_NONE;
        match_cnt <= 2'd0;
        locked_q  <= 1'b0;
        s_det     <= CODE_NONE;
        change_q  <= (s_det != CODE_NONE);
      end else begin
        case (state)
          ST_IDLE: begin
            if (tick_edge) state <= ST_MEASURE;
          end

          ST_MEASURE: begin
            if (tick_edge) begin
              if (cls == CODE_NONE) begin
                cand      <= CODE_NONE;
                match_cnt <= 2'd0;
              end else if (cls == cand) begin
                if (match_cnt != 2'd0) begin
                  match_cnt <= 2'd2;
                  state     <= ST_LOCKED;
                  s_det     <= cls;
                  locked_q  <= 1'b1;
                  change_q  <= 1'b1;
                end else begin
                  match_cnt <= 2'd1;
                end
              end else begin
                cand      <= cls;
                match_cnt <= 2'd1;
              end
            end else if (cnt == CNT_MAX) begin
              state     <= ST_IDLE;
              cand      <= CODE_NONE;
              match_cnt <= 2'd0;
            end
          end

          ST_LOCKED: begin
            if (tick_edge) begin
              if (cls != s_det) begin
                state     <= ST_MEASURE;
                s_det     <= CODE_NONE;
                locked_q  <= 1'b0;
                change_q  <= 1'b1;
                cand      <= cls;
                match_cnt <= (cls == CODE_NONE) ? 2'd0 : 2'd1;
              end
            end else if (cnt == CNT_MAX) begin
              state     <= ST_IDLE;
              s_det     <= CODE_NONE;
              locked_q  <= 1'b0;
              change_q  <= 1'b1;
              cand      <= CODE_NONE;
              match_cnt <= 2'd0;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.S_det  = s_det;
  assign bus.locked = locked_q;
  assign bus.change = change_q;

endmodule

// File: tb/tb_tick_rate_detector.sv
// Directed bench for tick_rate_detector at CLK_HZ=80 (TIMEOUT=240): expected
// change events are queued by the stimulus and checked by a separate monitor.
module tb_tick_rate_detector;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_rise = 0;

  typedef struct {
    int code;
    int lk;
    int at;
  } exp_t;

  exp_t exp_q[$];

  tick_rate_if bus ();

  tick_rate_detector #(.CLK_HZ(80)) dut (
    .clki (clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A rise driven at cycle r gives an edge pulse at r+3 and outputs at r+4.
  task automatic expect_chg(input int code, input int lk, input int at);
    exp_t e;
    e.code = code;
    e.lk   = lk;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic tick_first();
    @(negedge clk);
    bus.tick_in = 1'b1;
    last_rise = cyc;
    @(negedge clk);
    bus.tick_in = 1'b0;
  endtask

  task automatic tick_after(input int p);
    wait_to(last_rise + p);
    bus.tick_in = 1'b1;
    last_rise = cyc;
    @(negedge clk);
    bus.tick_in = 1'b0;
  endtask

  task automatic ticks(input int p, input int n);
    repeat (n) tick_after(p);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every change pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("invariant_locked_code", int'(bus.locked && bus.S_det == 2'b11), 0);
      if (bus.change) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_change: got S_det=%0d locked=%0d expected no change (cycle %0d)",
                   bus.S_det, bus.locked, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("chg_S_det", int'(bus.S_det), e.code);
          check("chg_locked", int'(bus.locked), e.lk);
          check("chg_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.E = 1'b1;
    bus.tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_S_det", int'(bus.S_det), 3);
    check("reset_locked", int'(bus.locked), 0);
    check("reset_change", int'(bus.change), 0);
    rst = 1'b0;

    // Period 80 locks at 01 on the third edge, then stays quiet.
    tick_first();
    tick_after(80);
    tick_after(80);
    expect_chg(1, 1, last_rise + 4);
    ticks(80, 10);
    wait_to(last_rise + 10);
    check("stable_S_det_01", int'(bus.S_det), 1);
    check("stable_locked_01", int'(bus.locked), 1);

    // Async reset mid-count while locked, then a fresh 3-edge relock.
    wait_to(last_rise + 30);
    rst = 1'b1;
    #1;
    check("async_rst_S_det", int'(bus.S_det), 3);
    check("async_rst_locked", int'(bus.locked), 0);
    check("async_rst_change", int'(bus.change), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick_first();
    tick_after(80);
    wait_to(last_rise + 6);
    check("two_edges_no_lock", int'(bus.locked), 0);
    tick_after(80);
    expect_chg(1, 1, last_rise + 4);

    // 01 -> 10 via period 40, then 10 -> 00 via period 160.
    tick_after(40);
    expect_chg(3, 0, last_rise + 4);
    tick_after(40);
    expect_chg(2, 1, last_rise + 4);
    ticks(40, 3);
    tick_after(160);
    expect_chg(3, 0, last_rise + 4);
    tick_after(160);
    expect_chg(0, 1, last_rise + 4);

    // Timeout: counter hits 240 at edge+240 (rise+243); drop visible one cycle later.
    expect_chg(3, 0, last_rise + 244);
    wait_to(last_rise + 250);
    check("timeout_locked", int'(bus.locked), 0);
    tick_after(260);
    wait_to(last_rise + 100);
    check("single_edge_no_lock", int'(bus.locked), 0);
    check("single_edge_S_det", int'(bus.S_det), 3);

    // Window boundaries: 90 in, 91 out, 35 in, 34 out.
    pulse_rst();
    tick_first();
    tick_after(90);
    tick_after(90);
    expect_chg(1, 1, last_rise + 4);
    tick_after(91);
    expect_chg(3, 0, last_rise + 4);
    ticks(91, 3);
    tick_after(35);
    tick_after(35);
    expect_chg(2, 1, last_rise + 4);
    tick_after(34);
    expect_chg(3, 0, last_rise + 4);
    ticks(34, 3);
    wait_to(last_rise + 10);
    check("p34_no_lock", int'(bus.locked), 0);
    check("p34_S_det", int'(bus.S_det), 3);

    // Enable drop while locked at 01, then relock after re-enable.
    tick_after(80);
    tick_after(80);
    expect_chg(1, 1, last_rise + 4);
    wait_to(last_rise + 20);
    expect_chg(3, 0, cyc + 1);
    bus.E = 1'b0;
    repeat (5) @(negedge clk);
    check("disable_S_det", int'(bus.S_det), 3);
    check("disable_locked", int'(bus.locked), 0);
    bus.E = 1'b1;
    tick_after(80);
    tick_after(80);
    wait_to(last_rise + 6);
    check("reenable_two_edges_no_lock", int'(bus.locked), 0);
    tick_after(80);
    expect_chg(1, 1, last_rise + 4);

    wait_to(last_rise + 20);
    check("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
